// File: rtl/transfer_sequencer.sv
// Drum bit/word timing generator and TR transfer-window sequencer for the
// G-15 early/intermediate bus path: IDLE -> WAIT -> XFER -> RCP -> IDLE.
module transfer_sequencer #(
    parameter int BITS_PER_WORD = 29,
    parameter int WORDS_PER_REV = 108
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       BIT_EN,
    input  logic       GO,
    input  logic [6:0] L,
    input  logic [6:0] N,
    input  logic       IMMED,
    input  logic       DOUBLE,
    input  logic       HALT,
    output logic [4:0] BIT,
    output logic [6:0] WORD,
    output logic       TS,
    output logic       TR,
    output logic       RC,
    output logic       DONE,
    output logic       BUSY
);

    localparam logic [4:0] BIT_LAST  = 5'(BITS_PER_WORD - 1);
    localparam logic [6:0] WORD_LAST = 7'(WORDS_PER_REV - 1);
    localparam logic [6:0] WORD_REV  = 7'(WORDS_PER_REV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_RCP
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] bit_q, bit_d;
    logic [6:0] word_q, word_d;
    logic [6:0] start_word_q, start_word_d;
    logic [6:0] stop_word_q, stop_word_d;
    logic       immed_q, immed_d;
    logic       double_q, double_d;

    logic       bit_wrap;
    logic [6:0] word_inc;
    logic [6:0] l_red;
    logic [6:0] n_red;
    logic [6:0] end_word;
    logic       start_hit;

    // Word addresses above the last drum word fold back by one revolution.
    function automatic logic [6:0] reduce_word(input logic [6:0] w);
        if (w >= WORD_REV) begin
            return w - WORD_REV;
        end
        return w;
    endfunction

    function automatic logic [6:0] next_word(input logic [6:0] w);
        if (w == WORD_LAST) begin
            return 7'd0;
        end
        return w + 7'd1;
    endfunction

    assign bit_wrap = (bit_q == BIT_LAST);
    assign word_inc = next_word(word_q);

    // Start/stop words are resolved once at GO, so WAIT/XFER only compare
    // against the word the counters are about to enter.
    assign l_red    = reduce_word(L);
    assign n_red    = reduce_word(N);
    assign end_word = DOUBLE ? (n_red | 7'd1) : n_red;

    assign start_hit = immed_q ? (!double_q || !word_inc[0])
                               : (word_inc == start_word_q);

    always_comb begin
        bit_d  = bit_q;
        word_d = word_q;
        if (BIT_EN) begin
            bit_d = bit_wrap ? 5'd0 : bit_q + 5'd1;
            if (bit_wrap) begin
                word_d = word_inc;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        start_word_d = start_word_q;
        stop_word_d  = stop_word_q;
        immed_d      = immed_q;
        double_d     = double_q;
        if (BIT_EN) begin
            if (HALT) begin
                state_d = S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (GO) begin
                            state_d      = S_WAIT;
                            start_word_d = DOUBLE ? {l_red[6:1], 1'b0} : l_red;
                            stop_word_d  = next_word(end_word);
                            immed_d      = IMMED;
                            double_d     = DOUBLE;
                        end
                    end
                    S_WAIT: begin
                        if (bit_wrap && start_hit) begin
                            state_d = S_XFER;
                        end
                    end
                    // The first boundary seen here is the end of the start word,
                    // so a full word is always transferred before the end check.
                    S_XFER: begin
                        if (bit_wrap && (word_inc == stop_word_q)) begin
                            state_d = S_RCP;
                        end
                    end
                    S_RCP: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= 5'd0;
            word_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        start_word_q <= start_word_d;
        stop_word_q  <= stop_word_d;
        immed_q      <= immed_d;
        double_q     <= double_d;
    end

    assign BIT  = bit_q;
    assign WORD = word_q;
    assign TS   = (bit_q == 5'd0);
    assign TR   = (state_q == S_XFER);
    assign RC   = (state_q == S_RCP);
    assign DONE = (state_q == S_RCP);
    assign BUSY = (state_q != S_IDLE);

endmodule
